sblock_cfg_loader: RTL and testbench
====================================

Name: sblock_cfg_loader

Overview:
Configuration loader that sits directly upstream of a chain of NUM_BLOCKS switch blocks. Each switch block has an 18-bit dot-control input and a high-enable latch strobe.
- Accepts a serial bitstream through a valid/ready handshake.
- Assembles one 18-bit word per switch block.
- Drives the shared 18-bit config bus and a one-hot, glitch-free write-enable per block, with setup and hold margins around each strobe.
- Signals completion after the last block has been written.

Parameters:
NUM_BLOCKS, 4, number of switch blocks served; block 0 is written first.
CFG_W, 18, bits per switch block (9 H dots + 9 V dots); fixed, not to be overridden.
SETUP_CYC, 1, cycles bits_o is stable before wr_en_o rises; must be >=1.
STROBE_CYC, 2, cycles wr_en_o is held high; must be >=1.
HOLD_CYC, 1, cycles bits_o is stable after wr_en_o falls; must be >=1.

Ports:
clk  input  1  clock.
rst  input  1  synchronous, active-high reset.
start_i  input  1  begin a full load; sampled only in IDLE.
cfg_bit_i  input  1  serial config bit, MSB of each word first (bit 17 = H dot 8).
cfg_valid_i  input  1  cfg_bit_i valid.
cfg_ready_o  output  1  loader accepts a bit this cycle.
bits_o  output  CFG_W  config word to all switch blocks; [17:9]=H, [8:0]=V.
wr_en_o  output  NUM_BLOCKS  one-hot latch enable, bit n to block n.
busy_o  output  1  load in progress.
done_o  output  1  one-cycle pulse: all blocks written.

Behaviour:
- Reset (clk edge with rst=1):
  - State goes to IDLE.
  - bits_o=0, wr_en_o=0, cfg_ready_o=0, busy_o=0, done_o=0.
  - Internal shift register, bit counter and block index are cleared.
- Reset mid-operation:
  - wr_en_o is 0 after that edge.
  - Partially shifted data is discarded.
  - The latches keep their last captured values.
- Registered outputs:
  - Every output is driven directly from a flop; no combinational logic on wr_en_o.
  - wr_en_o is never high in two bits at once.
- States: IDLE, SHIFT, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - cfg_ready_o=0.
  - start_i=1 → SHIFT, with blk_idx=0 and bit_cnt=0; busy_o=1 from that edge.
- SHIFT:
  - cfg_ready_o=1.
  - On valid&ready: shreg <= {shreg[CFG_W-2:0], cfg_bit_i} and bit_cnt++.
  - When the accepted bit is number CFG_W-1:
    - bits_o <= completed word, on that same edge.
    - bit_cnt <= 0.
    - cfg_ready_o <= 0.
    - → SETUP.
  - cfg_valid_i=0 stalls indefinitely; there is no timeout.
- SETUP: wait SETUP_CYC cycles; on exit, wr_en_o[blk_idx] <= 1 and → STROBE.
- STROBE: hold STROBE_CYC cycles; on exit, wr_en_o <= 0 and → HOLD.
- HOLD:
  - Wait HOLD_CYC cycles.
  - Then, if blk_idx==NUM_BLOCKS-1 → DONE; else blk_idx++ and → SHIFT.
- DONE: done_o=1 for exactly one cycle, busy_o=0, → IDLE.
- bits_o:
  - Changes only on the edge that completes a word.
  - Stable throughout SETUP, STROBE and HOLD.
  - Retains its last value in IDLE.
- Latency (defaults), with last bit of a word accepted at edge k:
  - bits_o valid at k.
  - wr_en_o high on edges k+1..k+2 and low at k+3.
  - cfg_ready_o high again at k+4 (next block), or done_o high at k+4 (last block).
- Full load: NUM_BLOCKS*CFG_W accepted bits; start_i is ignored while busy.
- Widths:
  - bit_cnt is $clog2(CFG_W) bits.
  - blk_idx is $clog2(NUM_BLOCKS) bits, minimum 1.
  - The wait counter is sized for max(SETUP_CYC, STROBE_CYC, HOLD_CYC).
  - No wrap: counters are reset on every state entry.

Decomposition:
- Package sblock_cfg_pkg:
  - CFG_W=18, DOTS=9, H_MSB=17, H_LSB=9, V_MSB=8, V_LSB=0.
  - State enum typedef cfg_state_t.
- One sub-module, cfg_deser: serial-to-parallel shift register plus bit counter, with a word_done pulse.
- The FSM, wait counter and one-hot wr_en_o generation stay in sblock_cfg_loader.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then start_i=0 for 10 cycles → all outputs 0, cfg_ready_o=0.
2. Single-word timing (NUM_BLOCKS=1):
   - Stimulus: stream 18'h2A5C3 continuously.
   - Response: bits_o=18'h2A5C3 at edge of the 18th bit; wr_en_o=1'b1 for exactly 2 cycles starting 1 cycle later; bits_o unchanged until done_o pulses 4 cycles after the last bit.
3. Full load (NUM_BLOCKS=4):
   - Stimulus: words 18'h3FFFF, 18'h00000, 18'h15555, 18'h2AAAA.
   - Response: wr_en_o sequence 0001, 0010, 0100, 1000, each 2 cycles, with the matching bits_o; one done_o pulse; busy_o low after.
4. Valid gaps:
   - Stimulus: deassert cfg_valid_i every 3rd cycle.
   - Response: same words captured; no extra or missing shifts; strobe timing relative to the last bit unchanged.
5. Reset mid-strobe:
   - Stimulus: assert rst while wr_en_o=0010.
   - Response: wr_en_o=0 and busy_o=0 at the next edge; a fresh start_i reloads from block 0 correctly.
6. start_i during load: pulse start_i while busy → ignored; no restart and no double done_o.

Source files
------------

// File: rtl/sblock_cfg_pkg.sv
// Shared constants and types for the switch-block configuration loader.
package sblock_cfg_pkg;

    // One configuration word per switch block: 9 horizontal dots, then 9 vertical dots.
    localparam int CFG_W = 18;
    localparam int DOTS  = 9;
    localparam int H_MSB = 17;
    localparam int H_LSB = 9;
    localparam int V_MSB = 8;
    localparam int V_LSB = 0;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } cfg_state_t;

    // Horizontal-dot field of a configuration word.
    function automatic logic [DOTS-1:0] cfg_h_dots(input logic [CFG_W-1:0] word);
        return word[H_MSB:H_LSB];
    endfunction

    // Vertical-dot field of a configuration word.
    function automatic logic [DOTS-1:0] cfg_v_dots(input logic [CFG_W-1:0] word);
        return word[V_MSB:V_LSB];
    endfunction

endpackage

// File: rtl/sblock_cfg_loader_deser.sv
// Serial-to-parallel converter: MSB-first shift register with a bit counter.
// word_next_o/word_done_o describe the bit being accepted this cycle, so the
// parent can register the completed word on the same edge as its last bit.
module cfg_deser
    import sblock_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [CFG_W-1:0] word_next_o,
    output logic             word_done_o
);

    localparam int CNT_W = $clog2(CFG_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);

    logic [CFG_W-1:0] shreg_q;
    logic [CFG_W-1:0] shreg_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic             last_bit_s;

    assign word_next_o = {shreg_q[CFG_W-2:0], bit_i};
    assign last_bit_s  = (bit_cnt_q == CNT_LAST);
    assign word_done_o = shift_en_i & last_bit_s;

    // Next shift-register contents and bit count.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (clr_i) begin
            shreg_d   = {CFG_W{1'b0}};
            bit_cnt_d = {CNT_W{1'b0}};
        end else if (shift_en_i) begin
            shreg_d = word_next_o;
            if (last_bit_s) begin
                bit_cnt_d = {CNT_W{1'b0}};
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else begin
            shreg_d   = shreg_q;
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Shift-register and counter flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q   <= {CFG_W{1'b0}};
            bit_cnt_q <= {CNT_W{1'b0}};
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/sblock_cfg_loader.sv
// Configuration loader for a chain of switch blocks: collects one serial word
// per block, then writes it with a setup / strobe / hold sequence on a
// one-hot latch enable. All outputs come straight from flops.
module sblock_cfg_loader
    import sblock_cfg_pkg::*;
#(
    parameter int NUM_BLOCKS = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  cfg_bit_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    output logic [CFG_W-1:0]      bits_o,
    output logic [NUM_BLOCKS-1:0] wr_en_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int BLK_W    = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int WAIT_MAX = (SETUP_CYC > STROBE_CYC)
                              ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                              : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [WAIT_W-1:0] SETUP_LAST  = WAIT_W'(SETUP_CYC - 1);
    localparam logic [WAIT_W-1:0] STROBE_LAST = WAIT_W'(STROBE_CYC - 1);
    localparam logic [WAIT_W-1:0] HOLD_LAST   = WAIT_W'(HOLD_CYC - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST    = BLK_W'(NUM_BLOCKS - 1);

    // One-hot latch enable for the addressed block.
    function automatic logic [NUM_BLOCKS-1:0] blk_onehot(input logic [BLK_W-1:0] idx);
        logic [NUM_BLOCKS-1:0] oh;
        oh = {NUM_BLOCKS{1'b0}};
        for (int n = 0; n < NUM_BLOCKS; n++) begin
            if (idx == BLK_W'(n)) begin
                oh[n] = 1'b1;
            end else begin
                oh[n] = 1'b0;
            end
        end
        return oh;
    endfunction

    cfg_state_t            state_q,    state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [BLK_W-1:0]      blk_idx_q,  blk_idx_d;
    logic [CFG_W-1:0]      bits_q,     bits_d;
    logic [NUM_BLOCKS-1:0] wr_en_q,    wr_en_d;
    logic                  ready_q,    ready_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic                  shift_en_s;
    logic                  deser_clr_s;
    logic [CFG_W-1:0]      word_s;
    logic                  word_done_s;

    // A bit moves only when the loader is shifting and advertised ready.
    assign shift_en_s  = cfg_valid_i & ready_q & (state_q == ST_SHIFT);
    // Idle keeps the deserialiser empty so every load starts from bit 0.
    assign deser_clr_s = (state_q == ST_IDLE);

    cfg_deser u_deser (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (deser_clr_s),
        .shift_en_i  (shift_en_s),
        .bit_i       (cfg_bit_i),
        .word_next_o (word_s),
        .word_done_o (word_done_s)
    );

    // Next-state and next-output logic of the load sequencer.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        blk_idx_d  = blk_idx_q;
        bits_d     = bits_q;
        wr_en_d    = wr_en_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_en_d = {NUM_BLOCKS{1'b0}};
                if (start_i) begin
                    state_d    = ST_SHIFT;
                    blk_idx_d  = {BLK_W{1'b0}};
                    wait_cnt_d = {WAIT_W{1'b0}};
                    ready_d    = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    ready_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (word_done_s) begin
                    bits_d     = word_s;
                    ready_d    = 1'b0;
                    wait_cnt_d = {WAIT_W{1'b0}};
                    state_d    = ST_SETUP;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_SETUP: begin
                if (wait_cnt_q == SETUP_LAST) begin
                    wr_en_d    = blk_onehot(blk_idx_q);
                    wait_cnt_d = {WAIT_W{1'b0}};
                    state_d    = ST_STROBE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_STROBE: begin
                if (wait_cnt_q == STROBE_LAST) begin
                    wr_en_d    = {NUM_BLOCKS{1'b0}};
                    wait_cnt_d = {WAIT_W{1'b0}};
                    state_d    = ST_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_HOLD: begin
                if (wait_cnt_q == HOLD_LAST) begin
                    wait_cnt_d = {WAIT_W{1'b0}};
                    if (blk_idx_q == BLK_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        blk_idx_d = blk_idx_q + BLK_W'(1);
                        ready_d   = 1'b1;
                        state_d   = ST_SHIFT;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                ready_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = {WAIT_W{1'b0}};
                wr_en_d    = {NUM_BLOCKS{1'b0}};
                ready_d    = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= {WAIT_W{1'b0}};
            blk_idx_q  <= {BLK_W{1'b0}};
            bits_q     <= {CFG_W{1'b0}};
            wr_en_q    <= {NUM_BLOCKS{1'b0}};
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            blk_idx_q  <= blk_idx_d;
            bits_q     <= bits_d;
            wr_en_q    <= wr_en_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign bits_o      = bits_q;
    assign wr_en_o     = wr_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_sblock_cfg_loader.sv
// Directed bench: a 4-block loader for full loads, gaps and reset, and a
// 1-block loader for single-word timing.
module tb_sblock_cfg_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start4 = 1'b0, bit4 = 1'b0, valid4 = 1'b0;
    logic        ready4, busy4, done4;
    logic [17:0] bits4;
    logic [3:0]  wr4;

    logic        start1 = 1'b0, bit1 = 1'b0, valid1 = 1'b0;
    logic        ready1, busy1, done1;
    logic [17:0] bits1;
    logic [0:0]  wr1;

    int errors = 0;
    int checks = 0;
    int gap_ctr = 0;
    int done_cnt4 = 0;

    always #5 clk = ~clk;

    sblock_cfg_loader #(.NUM_BLOCKS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .cfg_bit_i(bit4),
        .cfg_valid_i(valid4), .cfg_ready_o(ready4), .bits_o(bits4),
        .wr_en_o(wr4), .busy_o(busy4), .done_o(done4)
    );

    sblock_cfg_loader #(.NUM_BLOCKS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .cfg_bit_i(bit1),
        .cfg_valid_i(valid1), .cfg_ready_o(ready1), .bits_o(bits1),
        .wr_en_o(wr1), .busy_o(busy1), .done_o(done1)
    );

    // Count completion pulses of the 4-block loader.
    always @(posedge clk) begin
        if (done4) done_cnt4 <= done_cnt4 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start4();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("start_busy", busy4, 1);
        chk("start_ready", ready4, 1);
    endtask

    // Stream one word into the 4-block loader and check the write sequence.
    task automatic send4(input logic [17:0] w, input int blk, input bit last,
                         input bit gaps, input bit abort);
        int i;
        int guard;
        logic acc;
        logic [3:0] oh;
        i = 17;
        guard = 0;
        oh = 4'b0001 << blk;
        while (i >= 0 && guard < 200) begin
            if (gaps && (gap_ctr % 3 == 2)) begin
                valid4 = 1'b0;
            end else begin
                valid4 = 1'b1;
                bit4 = w[i];
            end
            acc = valid4 & ready4;
            tick();
            gap_ctr++;
            guard++;
            if (acc) i--;
        end
        valid4 = 1'b0;
        chk("accept_budget", (guard < 200), 1);
        // edge k: word complete
        chk("bits_at_k", bits4, w);
        chk("wr_at_k", wr4, 0);
        chk("ready_at_k", ready4, 0);
        tick();
        chk("wr_at_k1", wr4, oh);
        if (!abort) begin
            tick();
            chk("wr_at_k2", wr4, oh);
            chk("bits_at_k2", bits4, w);
            tick();
            chk("wr_at_k3", wr4, 0);
            chk("bits_at_k3", bits4, w);
            tick();
            chk("bits_at_k4", bits4, w);
            if (last) begin
                chk("done_at_k4", done4, 1);
                chk("busy_at_k4", busy4, 0);
                chk("ready_at_k4", ready4, 0);
                tick();
                chk("done_at_k5", done4, 0);
                chk("busy_at_k5", busy4, 0);
            end else begin
                chk("ready_at_k4", ready4, 1);
                chk("done_at_k4", done4, 0);
                chk("busy_at_k4", busy4, 1);
            end
        end
    endtask

    initial begin
        int d0;
        logic [17:0] w1;

        // Test 1: reset then idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle4", {ready4, busy4, done4, wr4, bits4}, 0);
            chk("idle1", {ready1, busy1, done1, wr1, bits1}, 0);
        end

        // Test 2: single-word timing on the 1-block loader
        w1 = 18'h2A5C3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("s1_ready", ready1, 1);
        for (int i = 17; i >= 0; i--) begin
            bit1 = w1[i];
            valid1 = 1'b1;
            tick();
        end
        valid1 = 1'b0;
        chk("s1_bits_k", bits1, 18'h2A5C3);
        chk("s1_wr_k", wr1, 0);
        tick();
        chk("s1_wr_k1", wr1, 1);
        tick();
        chk("s1_wr_k2", wr1, 1);
        tick();
        chk("s1_wr_k3", wr1, 0);
        chk("s1_bits_k3", bits1, 18'h2A5C3);
        tick();
        chk("s1_done_k4", done1, 1);
        chk("s1_busy_k4", busy1, 0);
        chk("s1_bits_k4", bits1, 18'h2A5C3);
        tick();
        chk("s1_done_k5", done1, 0);
        chk("s1_bits_idle", bits1, 18'h2A5C3);

        // Test 3: full load
        d0 = done_cnt4;
        pulse_start4();
        send4(18'h3FFFF, 0, 1'b0, 1'b0, 1'b0);
        send4(18'h00000, 1, 1'b0, 1'b0, 1'b0);
        send4(18'h15555, 2, 1'b0, 1'b0, 1'b0);
        send4(18'h2AAAA, 3, 1'b1, 1'b0, 1'b0);
        chk("full_done_cnt", done_cnt4 - d0, 1);
        chk("full_bits_idle", bits4, 18'h2AAAA);

        // Tests 4 and 6: valid gaps, start held high while busy
        d0 = done_cnt4;
        gap_ctr = 0;
        pulse_start4();
        send4(18'h12345, 0, 1'b0, 1'b1, 1'b0);
        start4 = 1'b1;
        send4(18'h0F0F0, 1, 1'b0, 1'b1, 1'b0);
        send4(18'h3C3C3, 2, 1'b0, 1'b1, 1'b0);
        start4 = 1'b0;
        send4(18'h20001, 3, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        chk("gap_done_cnt", done_cnt4 - d0, 1);
        chk("gap_no_restart", busy4, 0);

        // Test 5: reset mid-strobe, then a clean reload
        pulse_start4();
        send4(18'h11111, 0, 1'b0, 1'b0, 1'b0);
        send4(18'h22222, 1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk("rst_wr", wr4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_ready", ready4, 0);
        rst = 1'b0;
        tick();
        d0 = done_cnt4;
        pulse_start4();
        send4(18'h2A5C3, 0, 1'b0, 1'b0, 1'b0);
        send4(18'h1B6D9, 1, 1'b0, 1'b0, 1'b0);
        send4(18'h00001, 2, 1'b0, 1'b0, 1'b0);
        send4(18'h20000, 3, 1'b1, 1'b0, 1'b0);
        chk("reload_done_cnt", done_cnt4 - d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
